// File: rtl/inst_queue.sv
// In-order instruction queue between fetch and decode/dispatch. Stores {pc, inst}
// pairs, shows the head combinationally (a NOP when empty) and empties on a redirect flush.
module inst_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push_valid,
   input  logic [31:0]                push_pc,
   input  logic [31:0]                push_inst,
   output logic                       push_ready,
   input  logic                       pop,
   output logic                       head_valid,
   output logic [31:0]                head_pc,
   output logic [31:0]                head_inst,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;
   logic            push_ok, pop_ok;
   entry_t          head_entry;

   // Status depends only on registered occupancy, so no input reaches any output.
   assign push_ready = (count_q != CW'(DEPTH));
   assign head_valid = (count_q != '0);
   assign count      = count_q;

   assign push_ok = push_valid & push_ready & ~flush;
   assign pop_ok  = pop & head_valid & ~flush;

   // NOTE: every signal driven here gets a default first, so no latch can be inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; head outputs are gated by head_valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= '{pc: push_pc, inst: push_inst};
   end

   assign head_entry = mem_q[rd_ptr_q];
   assign head_pc    = head_valid ? head_entry.pc   : 32'h0;
   assign head_inst  = head_valid ? head_entry.inst : NOP_INST;

endmodule
